// File: rtl/sound_mixer.sv
// -----------------------------------------------------------------------------
// sound_mixer
//
// Multi-voice clip player and mixer. Up to NUM_VOICES clips (one-shot or
// looping) live concatenated in one shared sample ROM. On every sample_tick
// a frame walks the voices in order, reads one sample per active voice
// through the single ROM port, sums the samples around midscale and
// saturates the result into mix_sample.
//
// Optional feature macro: SOUND_MIXER_PWM_EN
//   defined   : builds a free-running PWM modulator driving pwm_out
//   undefined : pwm_out is tied low, no PWM counter is built
//
// Ports
//   clk_25MHZ     system clock
//   rst           synchronous, active-high reset
//   sample_tick   one-cycle strobe at the sample rate
//   trig_valid    trigger request
//   trig_ready    trigger accepted when trig_valid && trig_ready
//   trig_voice    target voice of the trigger
//   trig_base     clip start address
//   trig_len      clip length in samples, 0 stops the voice
//   trig_loop     1 = loop clip, 0 = one-shot
//   rom_addr      shared ROM read address (registered)
//   rom_data      ROM read data, valid ROM_LAT cycles after rom_addr
//   mix_sample    registered mixed sample
//   mix_valid     one-cycle pulse when mix_sample updates
//   voice_active  per-voice playing flags
//   voice_done    one-shot completion pulses, aligned with mix_valid
//   overrun       pulse when sample_tick arrives while a frame is running
//   pwm_out       PWM audio bitstream (0 unless SOUND_MIXER_PWM_EN)
//   dbg_state     current frame FSM state
//
// Trigger handshake: a trigger is taken on any rising clock edge where
// trig_valid && trig_ready are both high; trig_ready is high exactly while
// the frame FSM is idle, and trig_voice/base/len/loop must be stable while
// trig_valid is high.
// -----------------------------------------------------------------------------
module sound_mixer #(
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_W   = 8,
    parameter int ADDR_W     = 16,
    parameter int ROM_LAT    = 1
) (
    input  logic                                                  clk_25MHZ,
    input  logic                                                  rst,
    input  logic                                                  sample_tick,
    input  logic                                                  trig_valid,
    output logic                                                  trig_ready,
    input  logic [((NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1)-1:0] trig_voice,
    input  logic [ADDR_W-1:0]                                     trig_base,
    input  logic [ADDR_W-1:0]                                     trig_len,
    input  logic                                                  trig_loop,
    output logic [ADDR_W-1:0]                                     rom_addr,
    input  logic [SAMPLE_W-1:0]                                   rom_data,
    output logic [SAMPLE_W-1:0]                                   mix_sample,
    output logic                                                  mix_valid,
    output logic [NUM_VOICES-1:0]                                 voice_active,
    output logic [NUM_VOICES-1:0]                                 voice_done,
    output logic                                                  overrun,
    output logic                                                  pwm_out,
    output logic [2:0]                                            dbg_state
);

    localparam int VW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;

    localparam logic signed [ACC_W-1:0] MID_ACC   = ACC_W'(2 ** (SAMPLE_W - 1));
    localparam logic signed [ACC_W:0]   MAX_SUM   = (ACC_W + 1)'(2 ** SAMPLE_W - 1);
    localparam logic [SAMPLE_W-1:0]     MID_SMP   = SAMPLE_W'(2 ** (SAMPLE_W - 1));
    localparam logic [VW-1:0]           LAST_V    = VW'(NUM_VOICES - 1);
    localparam logic [1:0]              LAST_WAIT = 2'(ROM_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_ACCUM = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t                    r_state;
    logic [VW-1:0]             r_v;
    logic [1:0]                r_wait;
    logic signed [ACC_W-1:0]   r_acc;

    logic [ADDR_W-1:0]         r_base [NUM_VOICES];
    logic [ADDR_W-1:0]         r_len  [NUM_VOICES];
    logic [ADDR_W-1:0]         r_pos  [NUM_VOICES];
    logic [NUM_VOICES-1:0]     r_loop;
    logic [NUM_VOICES-1:0]     r_active;
    logic [NUM_VOICES-1:0]     r_done_pend;

    logic [ADDR_W-1:0]         r_rom_addr;
    logic [SAMPLE_W-1:0]       r_mix_sample;
    logic                      r_mix_valid;
    logic [NUM_VOICES-1:0]     r_voice_done;
    logic                      r_overrun;

    logic signed [ACC_W-1:0]   w_delta;
    logic signed [ACC_W:0]     w_sum;
    logic [SAMPLE_W-1:0]       w_sat;
    logic                      w_last;

    // Sample re-centred to a signed contribution around midscale.
    assign w_delta = $signed({{(ACC_W - SAMPLE_W){1'b0}}, rom_data}) - MID_ACC;

    // One extra bit so adding midscale back can never wrap.
    assign w_sum = {r_acc[ACC_W-1], r_acc} + {MID_ACC[ACC_W-1], MID_ACC};

    always_comb begin
        w_sat = w_sum[SAMPLE_W-1:0];
        if (w_sum[ACC_W]) begin
            w_sat = '0;
        end else if (w_sum > MAX_SUM) begin
            w_sat = '1;
        end
    end

    assign w_last = (r_pos[r_v] == r_len[r_v] - ADDR_W'(1));

    always_ff @(posedge clk_25MHZ) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_v          <= '0;
            r_wait       <= '0;
            r_acc        <= '0;
            r_loop       <= '0;
            r_active     <= '0;
            r_done_pend  <= '0;
            r_rom_addr   <= '0;
            r_mix_sample <= MID_SMP;
            r_mix_valid  <= 1'b0;
            r_voice_done <= '0;
            r_overrun    <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_base[i] <= '0;
                r_len[i]  <= '0;
                r_pos[i]  <= '0;
            end
        end else begin
            r_mix_valid  <= 1'b0;
            r_voice_done <= '0;
            r_overrun    <= sample_tick && (r_state != S_IDLE);

            case (r_state)
                S_IDLE: begin
                    // Trigger and tick may coincide: the voice registers are
                    // loaded here and the first FETCH already sees them.
                    if (trig_valid) begin
                        r_base[trig_voice]   <= trig_base;
                        r_len[trig_voice]    <= trig_len;
                        r_pos[trig_voice]    <= '0;
                        r_loop[trig_voice]   <= trig_loop;
                        r_active[trig_voice] <= (trig_len != '0);
                    end
                    if (sample_tick) begin
                        r_state <= S_FETCH;
                        r_v     <= '0;
                        r_acc   <= '0;
                    end
                end

                S_FETCH: begin
                    // Inactive voices keep the slot so the frame length is fixed.
                    if (r_active[r_v]) begin
                        r_rom_addr <= r_base[r_v] + r_pos[r_v];
                    end
                    r_wait  <= '0;
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    r_wait <= r_wait + 2'd1;
                    if (r_wait == LAST_WAIT) begin
                        r_state <= S_ACCUM;
                    end
                end

                S_ACCUM: begin
                    if (r_active[r_v]) begin
                        r_acc <= r_acc + w_delta;
                        if (w_last) begin
                            if (r_loop[r_v]) begin
                                r_pos[r_v] <= '0;
                            end else begin
                                r_active[r_v]    <= 1'b0;
                                r_done_pend[r_v] <= 1'b1;
                            end
                        end else begin
                            r_pos[r_v] <= r_pos[r_v] + ADDR_W'(1);
                        end
                    end
                    if (r_v == LAST_V) begin
                        r_state <= S_OUT;
                    end else begin
                        r_v     <= r_v + VW'(1);
                        r_state <= S_FETCH;
                    end
                end

                S_OUT: begin
                    r_mix_sample <= w_sat;
                    r_mix_valid  <= 1'b1;
                    r_voice_done <= r_done_pend;
                    r_done_pend  <= '0;
                    r_state      <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign trig_ready   = (r_state == S_IDLE);
    assign rom_addr     = r_rom_addr;
    assign mix_sample   = r_mix_sample;
    assign mix_valid    = r_mix_valid;
    assign voice_active = r_active;
    assign voice_done   = r_voice_done;
    assign overrun      = r_overrun;
    assign dbg_state    = r_state;

`ifdef SOUND_MIXER_PWM_EN
    logic [SAMPLE_W-1:0] r_pwm_cnt;
    logic [SAMPLE_W-1:0] r_duty;
    logic                r_pwm;

    // Duty only changes at counter wrap so a period is never cut short.
    always_ff @(posedge clk_25MHZ) begin
        if (rst) begin
            r_pwm_cnt <= '0;
            r_duty    <= '0;
            r_pwm     <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + SAMPLE_W'(1);
            if (r_pwm_cnt == '1) begin
                r_duty <= r_mix_sample;
            end
            r_pwm <= (r_pwm_cnt < r_duty);
        end
    end

    assign pwm_out = r_pwm;
`else
    assign pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_sound_mixer.sv
module tb_sound_mixer;

  localparam int NV    = 4;
  localparam int VW    = 2;
  localparam int FRAME = NV * (1 + 2) + 1;

  // ---------------- clock / reset block ----------------
  logic clk_25MHZ = 1'b0;
  always #20 clk_25MHZ = ~clk_25MHZ;

  logic          rst = 1'b1;
  logic          sample_tick = 1'b0;
  logic          trig_valid = 1'b0;
  logic          trig_ready;
  logic [VW-1:0] trig_voice = '0;
  logic [15:0]   trig_base = '0;
  logic [15:0]   trig_len = '0;
  logic          trig_loop = 1'b0;
  logic [15:0]   rom_addr;
  logic [7:0]    rom_data;
  logic [7:0]    mix_sample;
  logic          mix_valid;
  logic [NV-1:0] voice_active;
  logic [NV-1:0] voice_done;
  logic          overrun;
  logic          pwm_out;
  logic [2:0]    dbg_state;

  sound_mixer dut (
    .clk_25MHZ(clk_25MHZ), .rst(rst), .sample_tick(sample_tick),
    .trig_valid(trig_valid), .trig_ready(trig_ready), .trig_voice(trig_voice),
    .trig_base(trig_base), .trig_len(trig_len), .trig_loop(trig_loop),
    .rom_addr(rom_addr), .rom_data(rom_data), .mix_sample(mix_sample),
    .mix_valid(mix_valid), .voice_active(voice_active), .voice_done(voice_done),
    .overrun(overrun), .pwm_out(pwm_out), .dbg_state(dbg_state)
  );

  // shared sample ROM, one cycle read latency
  logic [7:0] rom [0:65535];
  logic [7:0] rom_q;
  always @(posedge clk_25MHZ) rom_q <= rom[rom_addr];
  assign rom_data = rom_q;

  // ---------------- behavioural model ----------------
  logic [15:0]   m_base [NV];
  logic [15:0]   m_len  [NV];
  logic [15:0]   m_pos  [NV];
  logic [NV-1:0] m_loop, m_act, m_done, pend_done;
  logic [7:0]    m_mix;
  logic          m_valid, m_ovr, m_init, m_accepted;
  int            m_busy;
  logic [7:0]    exp_q[$];

  // driver-side requested inputs for the next edge
  logic          d_rst = 1'b1, d_tick = 1'b0, d_tv = 1'b0, d_loop = 1'b0;
  logic [VW-1:0] d_voice = '0;
  logic [15:0]   d_base = '0, d_len = '0;

  // observation records used by the literal checks
  logic [7:0] obs_q[$];
  int obs_valid, obs_done0, obs_done_idx, obs_ovr, obs_ready_low;

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Whole frame evaluated at once: one sample per playing voice, summed
  // around midscale, clamped to the 8-bit range.
  task automatic model_frame();
    int sum;
    logic [NV-1:0] dn;
    sum = 0;
    dn = '0;
    for (int v = 0; v < NV; v++) begin
      if (m_act[v]) begin
        sum += int'(rom[16'(m_base[v] + m_pos[v])]) - 128;
        if (m_pos[v] + 16'd1 == m_len[v]) begin
          if (m_loop[v]) m_pos[v] = 16'd0;
          else begin
            m_act[v] = 1'b0;
            dn[v] = 1'b1;
          end
        end else m_pos[v] = m_pos[v] + 16'd1;
      end
    end
    sum += 128;
    if (sum < 0) sum = 0;
    if (sum > 255) sum = 255;
    exp_q.push_back(8'(sum));
    pend_done = dn;
  endtask

  task automatic model_step();
    m_accepted = 1'b0;
    if (d_rst) begin
      m_init = 1'b1;
      m_act = '0; m_loop = '0; m_done = '0; pend_done = '0;
      m_mix = 8'h80; m_valid = 1'b0; m_ovr = 1'b0; m_busy = 0;
      for (int v = 0; v < NV; v++) begin
        m_base[v] = '0; m_len[v] = '0; m_pos[v] = '0;
      end
      exp_q.delete();
    end else begin
      m_valid = 1'b0; m_done = '0; m_ovr = 1'b0;
      if (m_busy == 0) begin
        if (d_tv) begin
          m_base[d_voice] = d_base;
          m_len[d_voice] = d_len;
          m_pos[d_voice] = '0;
          m_loop[d_voice] = d_loop;
          m_act[d_voice] = (d_len != 16'd0);
          m_accepted = 1'b1;
        end
        if (d_tick) begin
          model_frame();
          m_busy = FRAME;
        end
      end else begin
        if (d_tick) m_ovr = 1'b1;
        m_busy--;
        if (m_busy == 0) begin
          m_mix = exp_q.pop_front();
          m_valid = 1'b1;
          m_done = pend_done;
        end
      end
    end
  endtask

  // ---------------- per-cycle compare ----------------
  task automatic observe();
    if (mix_valid) begin
      obs_valid++;
      obs_q.push_back(mix_sample);
      if (voice_done[0]) obs_done_idx = obs_q.size();
    end
    if (voice_done[0]) obs_done0++;
    if (overrun) obs_ovr++;
    if (!trig_ready) obs_ready_low++;
  endtask

  task automatic compare();
    chk("mix_sample", 32'(mix_sample), 32'(m_mix));
    chk("mix_valid", 32'(mix_valid), 32'(m_valid));
    chk("voice_done", 32'(voice_done), 32'(m_done));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("trig_ready", 32'(trig_ready), 32'(m_busy == 0));
    if (m_busy == 0) chk("voice_active", 32'(voice_active), 32'(m_act));
`ifndef SOUND_MIXER_PWM_EN
    chk("pwm_out", 32'(pwm_out), 32'd0);
`endif
  endtask

  // one clock: check outputs, drive inputs, advance model, wait for next negedge
  task automatic cycle();
    if (m_init) begin
      observe();
      compare();
    end
    rst = d_rst; sample_tick = d_tick; trig_valid = d_tv;
    trig_voice = d_voice; trig_base = d_base; trig_len = d_len; trig_loop = d_loop;
    model_step();
    @(posedge clk_25MHZ);
    @(negedge clk_25MHZ);
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_obs();
    obs_q.delete();
    obs_valid = 0; obs_done0 = 0; obs_done_idx = 0; obs_ovr = 0; obs_ready_low = 0;
  endtask

  task automatic trigger(input int v, input logic [15:0] b, input logic [15:0] l, input logic lp,
                         input logic with_tick);
    d_tv = 1'b1; d_voice = VW'(v); d_base = b; d_len = l; d_loop = lp; d_tick = with_tick;
    cycle();
    d_tv = 1'b0; d_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic tick_frame();
    d_tick = 1'b1;
    cycle();
    d_tick = 1'b0;
    idle(FRAME + 2);
  endtask

  task automatic lit(input string name, input int idx, input logic [7:0] exp);
    if (idx < obs_q.size()) chk(name, 32'(obs_q[idx]), 32'(exp));
    else chk(name, 32'hFFFF_FFFF, 32'(exp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_init = 1'b0;
    m_busy = 0;
    for (int a = 0; a < 65536; a++) rom[a] = 8'($urandom_range(0, 255));
    clear_obs();
    @(negedge clk_25MHZ);

    // reset
    d_rst = 1'b1;
    idle(3);
    chk("reset_rom_addr", 32'(rom_addr), 32'd0);
    chk("reset_mix", 32'(mix_sample), 32'h80);
    chk("reset_ready", 32'(trig_ready), 32'd1);
    d_rst = 1'b0;

    // three ticks, nothing playing
    clear_obs();
    for (int i = 0; i < 3; i++) tick_frame();
    chk("silent_valid_count", 32'(obs_valid), 32'd3);
    for (int i = 0; i < 3; i++) lit("silent_mix", i, 8'h80);
    chk("silent_active", 32'(voice_active), 32'd0);

    // one-shot clip on voice 0
    rom[16'h100] = 8'h90; rom[16'h101] = 8'hA0; rom[16'h102] = 8'h70;
    clear_obs();
    trigger(0, 16'h100, 16'd3, 1'b0, 1'b0);
    chk("oneshot_active", 32'(voice_active[0]), 32'd1);
    for (int i = 0; i < 4; i++) tick_frame();
    lit("oneshot_s0", 0, 8'h90);
    lit("oneshot_s1", 1, 8'hA0);
    lit("oneshot_s2", 2, 8'h70);
    lit("oneshot_s3", 3, 8'h80);
    chk("oneshot_done_count", 32'(obs_done0), 32'd1);
    chk("oneshot_done_at", 32'(obs_done_idx), 32'd3);
    chk("oneshot_active_fall", 32'(voice_active[0]), 32'd0);

    // looping clip, trigger coinciding with the first tick
    clear_obs();
    trigger(0, 16'h100, 16'd3, 1'b1, 1'b1);
    idle(FRAME + 2);
    for (int i = 0; i < 3; i++) tick_frame();
    lit("loop_s0", 0, 8'h90);
    lit("loop_s1", 1, 8'hA0);
    lit("loop_s2", 2, 8'h70);
    lit("loop_s3", 3, 8'h90);
    chk("loop_no_done", 32'(obs_done0), 32'd0);

    // saturation high and low
    for (int a = 16'h200; a < 16'h210; a++) rom[a] = 8'hFF;
    for (int a = 16'h300; a < 16'h310; a++) rom[a] = 8'h00;
    clear_obs();
    for (int v = 0; v < NV; v++) trigger(v, 16'h200, 16'd16, 1'b0, 1'b0);
    tick_frame();
    for (int v = 0; v < NV; v++) trigger(v, 16'h300, 16'd16, 1'b0, 1'b0);
    tick_frame();
    lit("sat_high", 0, 8'hFF);
    lit("sat_low", 1, 8'h00);

    // overrun plus a trigger held through the frame
    for (int v = 0; v < NV; v++) trigger(v, 16'h0, 16'd0, 1'b0, 1'b0);
    clear_obs();
    d_tick = 1'b1; cycle();
    d_tick = 1'b0; cycle();
    d_tick = 1'b1; cycle();
    d_tick = 1'b0;
    d_tv = 1'b1; d_voice = 2'd2; d_base = 16'h100; d_len = 16'd3; d_loop = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      cycle();
      if (m_accepted) break;
    end
    d_tv = 1'b0;
    idle(FRAME + 2);
    chk("overrun_count", 32'(obs_ovr), 32'd1);
    chk("overrun_valid_count", 32'(obs_valid), 32'd1);
    chk("held_ready_low", 32'(obs_ready_low), 32'(FRAME));
    chk("held_accepted", 32'(voice_active), 32'b0100);

    // reset in the middle of a frame with two voices playing
    trigger(0, 16'h100, 16'd3, 1'b1, 1'b0);
    trigger(1, 16'h200, 16'd16, 1'b1, 1'b0);
    clear_obs();
    d_tick = 1'b1; cycle();
    d_tick = 1'b0; idle(4);
    d_rst = 1'b1; cycle();
    d_rst = 1'b0; cycle();
    chk("midrst_active", 32'(voice_active), 32'd0);
    chk("midrst_mix", 32'(mix_sample), 32'h80);
    chk("midrst_addr", 32'(rom_addr), 32'd0);
    idle(FRAME + 4);
    chk("midrst_no_valid", 32'(obs_valid), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      d_rst   = ($urandom_range(0, 699) == 0);
      d_tick  = ($urandom_range(0, 15) == 0);
      d_tv    = ($urandom_range(0, 5) == 0);
      d_voice = VW'($urandom_range(0, NV - 1));
      d_base  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF8, 16'hFFFF))
                                            : 16'($urandom_range(0, 16'hFFFF));
      d_len   = 16'($urandom_range(0, 6));
      d_loop  = 1'($urandom_range(0, 1));
      cycle();
    end
    d_rst = 1'b0; d_tick = 1'b0; d_tv = 1'b0;
    idle(FRAME + 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sound_mixer.md
Name: sound_mixer

Overview:
- Multi-voice clip player and mixer; successor to the single-clip audio player.
- Plays up to NUM_VOICES independent clips at once (one-shot or looping) from one shared sample ROM: all clips concatenated in a single_port_bram_with_rst image.
- On each sample strobe, reads one sample per voice through a single time-multiplexed ROM port and sums them around midscale with saturation.
- Outputs a registered mixed sample, and optionally a PWM bitstream, toward the board audio pin.

Parameters:
- NUM_VOICES, 4, number of simultaneous voices (1..8).
- SAMPLE_W, 8, sample width; unsigned, midscale 2^(SAMPLE_W-1).
- ADDR_W, 16, shared sample ROM address width.
- ROM_LAT, 1, ROM read latency in clocks (1..2).

Ports:
- clk_25MHZ  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sample_tick  in  1  one-cycle strobe at the sample rate (8 kHz); a strobe, not a clock.
- trig_valid  in  1  trigger request.
- trig_ready  out  1  trigger accepted when trig_valid && trig_ready.
- trig_voice  in  $clog2(NUM_VOICES) (min 1)  target voice.
- trig_base  in  ADDR_W  clip start address.
- trig_len  in  ADDR_W  clip length in samples; 0 = stop voice.
- trig_loop  in  1  1 = loop clip, 0 = one-shot.
- rom_addr  out  ADDR_W  shared ROM read address.
- rom_data  in  SAMPLE_W  ROM data, valid ROM_LAT cycles after rom_addr.
- mix_sample  out  SAMPLE_W  mixed output sample.
- mix_valid  out  1  one-cycle pulse when mix_sample updates.
- voice_active  out  NUM_VOICES  per-voice playing flag.
- voice_done  out  NUM_VOICES  one-shot completion pulses, aligned with mix_valid.
- overrun  out  1  pulse when a sample_tick arrives while a frame is in progress.
- pwm_out  out  1  PWM audio (see Optional Feature).

Behaviour:
- Reset values:
  - All voices inactive; pos = 0.
  - mix_sample = midscale (0x80 at SAMPLE_W = 8).
  - mix_valid, voice_done, overrun, pwm_out = 0.
  - rom_addr = 0; trig_ready = 1; FSM = IDLE.
  - rst mid-frame aborts the frame with no mix_valid.
- Per-voice state: base, len, pos, loop, active.
- Trigger, in IDLE only (trig_ready = FSM==IDLE):
  - Loads base, len and loop; sets pos = 0; active = (len != 0).
  - Retriggering an active voice restarts it from pos 0.
  - len = 0 stops the voice immediately.
- FSM IDLE:
  - sample_tick -> FETCH(v = 0), acc = 0.
  - Trigger and tick in the same cycle: both accepted; this frame plays sample 0 of the new clip.
- FSM FETCH(v):
  - rom_addr = base[v] + pos[v], truncated to ADDR_W (wraps).
  - Go to WAIT for ROM_LAT cycles, then ACCUM.
  - Inactive voices skip the fetch and contribute 0; the frame length stays constant.
- FSM ACCUM(v):
  - Signed accumulator, SAMPLE_W + $clog2(NUM_VOICES) + 1 bits.
  - If active: acc += rom_data - midscale.
  - Advance pos: if pos == len-1, then loop ? pos = 0 : (active = 0, voice_done[v] pending); else pos += 1.
  - If v == NUM_VOICES-1 go to OUT, else FETCH(v+1).
- FSM OUT:
  - mix_sample = saturate(acc + midscale) to [0, 2^SAMPLE_W - 1].
  - Pulse mix_valid and any pending voice_done bits; return to IDLE.
- Frame length: NUM_VOICES*(ROM_LAT+2) + 1 cycles, far below the 3125-cycle tick period.
- sample_tick outside IDLE: ignored and overrun pulsed for 1 cycle; no queuing.
- voice_active reflects the registered active bits.

Optional Feature:
- Macro: SOUND_MIXER_PWM_EN.
- Defined:
  - Free-running SAMPLE_W-bit counter; pwm_out = (counter < duty), period 2^SAMPLE_W clocks.
  - duty is latched from mix_sample only at counter wrap, so there is no glitching mid-period.
- Not defined: pwm_out is tied to 0 and no counter logic is built; downstream uses mix_sample with an external pwm.

Test Plan:
- Reset, then 3 ticks, no triggers -> mix_sample stays 0x80, mix_valid pulses 3 times, voice_active = 0.
- Voice 0: base = 0x100, len = 3, loop = 0; ROM[0x100..0x102] = 0x90, 0xA0, 0x70 -> outputs 0x90, 0xA0, 0x70, then 0x80; voice_done[0] pulses with the 3rd mix_valid; voice_active[0] falls.
- Same clip with loop = 1 -> output sequence 0x90, 0xA0, 0x70, 0x90, ...; no voice_done.
- Voices 0–3 each reading constant 0xFF -> acc = 4*127; mix_sample saturates to 0xFF. All reading 0x00 -> saturates to 0x00.
- Tick asserted again 2 cycles after a frame starts -> overrun = 1 for one cycle; only one mix_valid. Trigger held during the frame -> trig_ready = 0 until IDLE, then accepted.
- rst asserted mid-frame with 2 voices active -> no mix_valid; all outputs return to reset values on the next cycle.
